// File: rtl/evm_vote_controller_if.sv
// Ballot controller bus: officer arm, candidate keys, tally memory read/write and status.
// master = controller side, slave = officer/keypad/tally-memory side.
interface evm_vote_controller_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 4
);
  logic                      arm;
  logic [NUM_CAND-1:0]       cand_btn;
  logic [NUM_CAND*CNT_W-1:0] mem_rd_data;
  logic [NUM_CAND*CNT_W-1:0] mem_wr_data;
  logic [NUM_CAND-1:0]       mem_we;
  logic                      ballot_ready;
  logic                      vote_done;
  logic                      invalid_press;
  logic                      overflow_err;
`ifdef EVM_TALLY_CLEAR_EN
  logic                      clear_req;
`endif

  modport master (
`ifdef EVM_TALLY_CLEAR_EN
    input  clear_req,
`endif
    input  arm, cand_btn, mem_rd_data,
    output mem_wr_data, mem_we, ballot_ready, vote_done, invalid_press, overflow_err
  );

  modport slave (
`ifdef EVM_TALLY_CLEAR_EN
    output clear_req,
`endif
    output arm, cand_btn, mem_rd_data,
    input  mem_wr_data, mem_we, ballot_ready, vote_done, invalid_press, overflow_err
  );
endinterface

// File: rtl/evm_vote_controller.sv
// Ballot controller: one arm -> one accepted key -> read-modify-write of that candidate's tally.
// Latency: key registered at E0, mem_we E1..E2, vote_done E2..E3; no backpressure, arm outside IDLE is dropped.
// Optional EVM_TALLY_CLEAR_EN adds clear_req and a one-cycle CLEAR of every tally and overflow_err.
module evm_vote_controller #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  evm_vote_controller_if.master bus
);
  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WRITE,
    DONE,
    REJECT,
    RELEASE,
`ifdef EVM_TALLY_CLEAR_EN
    CLEAR,
`endif
    RELEASE_R
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                    state_q, state_d;
  logic [NUM_CAND-1:0]       btn_q, btn_d;
  logic [NUM_CAND-1:0]       btn_prev_q, btn_prev_d;
  logic [NUM_CAND-1:0]       mem_we_q, mem_we_d;
  logic                      ballot_ready_q, ballot_ready_d;
  logic                      vote_done_q, vote_done_d;
  logic                      invalid_press_q, invalid_press_d;
  logic                      overflow_err_q, overflow_err_d;
  logic [NUM_CAND-1:0]       rise;
  int                        n_pressed;
  logic [NUM_CAND*CNT_W-1:0] wr_data;

  always_comb begin
    rise           = btn_q & ~btn_prev_q;
    n_pressed      = $countones(btn_q);
    state_d        = state_q;
    btn_d          = bus.cand_btn;
    btn_prev_d     = btn_q;
    mem_we_d       = '0;
    overflow_err_d = overflow_err_q;
    case (state_q)
      IDLE: begin
`ifdef EVM_TALLY_CLEAR_EN
        if (bus.clear_req) begin
          state_d        = CLEAR;
          mem_we_d       = '1;
          overflow_err_d = 1'b0;
        end else
`endif
        if (bus.arm) state_d = ARMED;
      end
      ARMED: begin
        if (n_pressed >= 2) begin
          state_d = REJECT;
        end else if (n_pressed == 1 && rise != '0) begin
          state_d = WRITE;
          // btn_q is the one-hot index; the tally cannot move before the write, so saturation is judged now
          for (int i = 0; i < NUM_CAND; i++) begin
            if (btn_q[i] && bus.mem_rd_data[i*CNT_W +: CNT_W] != CNT_MAX) mem_we_d[i] = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = DONE;
        if (mem_we_q == '0) overflow_err_d = 1'b1;
      end
      DONE:      state_d = RELEASE;
      REJECT:    state_d = RELEASE_R;
      RELEASE:   if (btn_q == '0) state_d = IDLE;
      RELEASE_R: if (btn_q == '0) state_d = ARMED;
`ifdef EVM_TALLY_CLEAR_EN
      CLEAR:     state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
    ballot_ready_d  = (state_d == ARMED);
    vote_done_d     = (state_d == DONE);
    invalid_press_d = (state_d == REJECT);
  end

  always_comb begin
    wr_data = bus.mem_rd_data;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (mem_we_q[i]) wr_data[i*CNT_W +: CNT_W] = bus.mem_rd_data[i*CNT_W +: CNT_W] + CNT_ONE;
    end
`ifdef EVM_TALLY_CLEAR_EN
    if (state_q == CLEAR) wr_data = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      btn_q           <= '0;
      btn_prev_q      <= '0;
      mem_we_q        <= '0;
      ballot_ready_q  <= 1'b0;
      vote_done_q     <= 1'b0;
      invalid_press_q <= 1'b0;
      overflow_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      btn_q           <= btn_d;
      btn_prev_q      <= btn_prev_d;
      mem_we_q        <= mem_we_d;
      ballot_ready_q  <= ballot_ready_d;
      vote_done_q     <= vote_done_d;
      invalid_press_q <= invalid_press_d;
      overflow_err_q  <= overflow_err_d;
    end
  end

  assign bus.mem_wr_data   = wr_data;
  assign bus.mem_we        = mem_we_q;
  assign bus.ballot_ready  = ballot_ready_q;
  assign bus.vote_done     = vote_done_q;
  assign bus.invalid_press = invalid_press_q;
  assign bus.overflow_err  = overflow_err_q;
endmodule

// File: tb/tb_evm_vote_controller.sv
// Bench for evm_vote_controller: tally memory stand-in, timeline-based ballot model checked every cycle,
// directed ballots with literal expectations, then randomized keys/arm/reset.
module tb_evm_vote_controller;
  localparam int NC = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  evm_vote_controller_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();
  evm_vote_controller #(.NUM_CAND(NC), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Tally memory blocks: combinational read, write on mem_we, no reset
  logic [CW-1:0] tally   [NC];
  logic [CW-1:0] pre_val [NC];
  bit            pre_vld;

  always_comb for (int i = 0; i < NC; i++) bus.mem_rd_data[i*CW +: CW] = tally[i];

  always @(posedge clk) begin
    if (pre_vld) for (int i = 0; i < NC; i++) tally[i] <= pre_val[i];
    else for (int i = 0; i < NC; i++) if (bus.mem_we[i]) tally[i] <= bus.mem_wr_data[i*CW +: CW];
  end

  // Ballot model: tracks the voter's progress as a timeline (open ballot, pending completion,
  // cycles to wait, waiting for keys to clear) and predicts the outputs for the coming cycle.
  bit [CW-1:0] exp_cnt [NC];
  bit [NC-1:0] m_btn, m_prev, e_we;
  bit          e_ready, e_done, e_inv, e_ovf, e_clr;
  bit          started, open, reopen, wait_rel, pend, pend_sat;
  int          delay;

  always @(posedge clk) begin : model
    bit [NC-1:0] rise, n_we;
    bit          n_done, n_inv, n_clr;
    int          k;
    if (pre_vld) for (int i = 0; i < NC; i++) exp_cnt[i] = pre_val[i];
    else for (int i = 0; i < NC; i++) if (e_we[i]) exp_cnt[i] = e_clr ? '0 : CW'(exp_cnt[i] + 1);
    rise   = m_btn & ~m_prev;
    n_we   = '0;
    n_done = 1'b0;
    n_inv  = 1'b0;
    n_clr  = 1'b0;
    if (!rst_n) begin
      started  = 1'b1;
      open     = 1'b0;
      wait_rel = 1'b0;
      pend     = 1'b0;
      delay    = 0;
      e_ovf    = 1'b0;
      m_btn    = '0;
      m_prev   = '0;
    end else begin
      if (delay > 0) begin
        delay--;
        if (pend) begin
          pend   = 1'b0;
          n_done = 1'b1;
          if (pend_sat) e_ovf = 1'b1;
        end
      end else if (wait_rel) begin
        if (m_btn == '0) begin
          wait_rel = 1'b0;
          open     = reopen;
        end
      end else if (open) begin
        k = $countones(m_btn);
        if (k >= 2) begin
          open = 1'b0; n_inv = 1'b1; wait_rel = 1'b1; reopen = 1'b1; delay = 1;
        end else if (k == 1 && rise != '0) begin
          open = 1'b0; wait_rel = 1'b1; reopen = 1'b0; delay = 2; pend = 1'b1;
          for (int i = 0; i < NC; i++) begin
            if (m_btn[i]) begin
              pend_sat = (exp_cnt[i] == 4'hF);
              n_we[i]  = !pend_sat;
            end
          end
        end
      end
`ifdef EVM_TALLY_CLEAR_EN
      else if (bus.clear_req) begin
        n_we = '1; n_clr = 1'b1; e_ovf = 1'b0; delay = 1;
      end
`endif
      else if (bus.arm) open = 1'b1;
      m_prev = m_btn;
      m_btn  = bus.cand_btn;
    end
    e_we    = n_we;
    e_done  = n_done;
    e_inv   = n_inv;
    e_clr   = n_clr;
    e_ready = open;
  end

  always @(negedge clk) begin : compare
    logic [NC*CW-1:0] w;
    if (started) begin
      for (int i = 0; i < NC; i++)
        w[i*CW +: CW] = e_clr ? '0 : (e_we[i] ? CW'(exp_cnt[i] + 1) : exp_cnt[i]);
      chk("cyc_mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("cyc_mem_wr_data", 32'(bus.mem_wr_data), 32'(w));
      chk("cyc_ballot_ready", 32'(bus.ballot_ready), 32'(e_ready));
      chk("cyc_vote_done", 32'(bus.vote_done), 32'(e_done));
      chk("cyc_invalid_press", 32'(bus.invalid_press), 32'(e_inv));
      chk("cyc_overflow_err", 32'(bus.overflow_err), 32'(e_ovf));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [CW-1:0] c0, c1, c2, c3);
    rst_n = 1'b0;
    bus.arm = 1'b0;
    bus.cand_btn = '0;
`ifdef EVM_TALLY_CLEAR_EN
    bus.clear_req = 1'b0;
`endif
    pre_val[0] = c0; pre_val[1] = c1; pre_val[2] = c2; pre_val[3] = c3;
    pre_vld = 1'b1;
    cyc(1);
    pre_vld = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [CW-1:0] c0, c1, c2, c3);
    pre_val[0] = c0; pre_val[1] = c1; pre_val[2] = c2; pre_val[3] = c3;
    pre_vld = 1'b1;
    cyc(1);
    pre_vld = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    cyc(1);
    bus.arm = 1'b0;
  endtask

  // Hold keys for `hold` cycles, release, settle; report what the DUT emitted meanwhile
  task automatic press(input logic [NC-1:0] keys, input int hold,
                       output logic [NC-1:0] we_or, output logic done_or, output logic inv_or);
    we_or = '0; done_or = 1'b0; inv_or = 1'b0;
    bus.cand_btn = keys;
    for (int c = 0; c < hold + 4; c++) begin
      if (c == hold) bus.cand_btn = '0;
      cyc(1);
      we_or   |= bus.mem_we;
      done_or |= bus.vote_done;
      inv_or  |= bus.invalid_press;
    end
  endtask

  initial begin
    logic [NC-1:0] we_or;
    logic          done_or, inv_or;

    // Reset state and first-vote latency
    do_reset(4'd0, 4'd0, 4'd0, 4'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_ready", 32'(bus.ballot_ready), 0);
    chk("rst_ovf", 32'(bus.overflow_err), 0);
    pulse_arm();
    chk("arm_ready", 32'(bus.ballot_ready), 1);
    bus.cand_btn = 4'b0010;
    cyc(1);
    chk("lat_e0_we", 32'(bus.mem_we), 0);
    cyc(1);
    chk("lat_e1_we", 32'(bus.mem_we), 4'b0010);
    chk("lat_wr_slice", 32'(bus.mem_wr_data[7:4]), 1);
    chk("lat_ready_drop", 32'(bus.ballot_ready), 0);
    cyc(1);
    chk("lat_done", 32'(bus.vote_done), 1);
    chk("lat_we_single", 32'(bus.mem_we), 0);
    chk("lat_tally1", 32'(tally[1]), 1);
    cyc(2);
    bus.cand_btn = '0;
    cyc(3);
    chk("idle_ready", 32'(bus.ballot_ready), 0);

    // Saturation
    preload(4'd14, 4'd0, 4'd0, 4'd0);
    pulse_arm();
    press(4'b0001, 3, we_or, done_or, inv_or);
    chk("sat1_we", 32'(we_or), 4'b0001);
    chk("sat1_tally0", 32'(tally[0]), 15);
    pulse_arm();
    press(4'b0001, 3, we_or, done_or, inv_or);
    chk("sat2_we", 32'(we_or), 0);
    chk("sat2_done", 32'(done_or), 1);
    chk("sat2_ovf", 32'(bus.overflow_err), 1);
    chk("sat2_tally0", 32'(tally[0]), 15);

    // Multi-key reject then retry
    pulse_arm();
    press(4'b0101, 3, we_or, done_or, inv_or);
    chk("rej_inv", 32'(inv_or), 1);
    chk("rej_we", 32'(we_or), 0);
    chk("rej_rearmed", 32'(bus.ballot_ready), 1);
    press(4'b0100, 3, we_or, done_or, inv_or);
    chk("retry_we", 32'(we_or), 4'b0100);
    chk("retry_ready", 32'(bus.ballot_ready), 0);
    chk("retry_tally2", 32'(tally[2]), 1);

    // Key held across arm is not accepted until re-pressed
    bus.cand_btn = 4'b1000;
    cyc(2);
    pulse_arm();
    we_or = '0;
    repeat (4) begin
      cyc(1);
      we_or |= bus.mem_we;
    end
    chk("held_we", 32'(we_or), 0);
    bus.cand_btn = '0;
    cyc(2);
    press(4'b1000, 3, we_or, done_or, inv_or);
    chk("repress_we", 32'(we_or), 4'b1000);
    chk("repress_tally3", 32'(tally[3]), 1);
    press(4'b1000, 3, we_or, done_or, inv_or);
    chk("noarm_we", 32'(we_or), 0);

    // Reset during the WRITE cycle: the edge still captures, nothing after it
    preload(4'd5, 4'd0, 4'd0, 4'd0);
    pulse_arm();
    bus.cand_btn = 4'b0001;
    cyc(2);
    chk("wr_rst_pre_we", 32'(bus.mem_we), 4'b0001);
    rst_n = 1'b0;
    cyc(1);
    chk("wr_rst_we", 32'(bus.mem_we), 0);
    chk("wr_rst_done", 32'(bus.vote_done), 0);
    rst_n = 1'b1;
    bus.cand_btn = '0;
    cyc(2);
    chk("wr_rst_done_late", 32'(bus.vote_done), 0);
    chk("wr_rst_tally0", 32'(tally[0]), 6);

`ifdef EVM_TALLY_CLEAR_EN
    preload(4'd3, 4'd2, 4'd1, 4'd15);
    pulse_arm();
    press(4'b1000, 3, we_or, done_or, inv_or);
    chk("clr_pre_ovf", 32'(bus.overflow_err), 1);
    bus.clear_req = 1'b1;
    cyc(1);
    bus.clear_req = 1'b0;
    chk("clr_we", 32'(bus.mem_we), 4'b1111);
    chk("clr_wr_data", 32'(bus.mem_wr_data), 0);
    chk("clr_ovf", 32'(bus.overflow_err), 0);
    cyc(1);
    chk("clr_tally", 32'({tally[3], tally[2], tally[1], tally[0]}), 0);
`endif

    // Randomized keys, arm and occasional reset, checked by the model every cycle
    do_reset(4'd13, 4'd14, 4'd15, 4'd12);
    for (int c = 0; c < 2500; c++) begin
      bus.arm = ($urandom_range(0, 7) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.cand_btn = '0;
          3:       bus.cand_btn = 4'($urandom_range(0, 15));
          default: bus.cand_btn = 4'(1 << $urandom_range(0, NC - 1));
        endcase
      end
`ifdef EVM_TALLY_CLEAR_EN
      bus.clear_req = ($urandom_range(0, 63) == 0);
`endif
      cyc(1);
    end
    rst_n = 1'b1;
    bus.arm = 1'b0;
    bus.cand_btn = '0;
`ifdef EVM_TALLY_CLEAR_EN
    bus.clear_req = 1'b0;
`endif
    cyc(6);
    for (int i = 0; i < NC; i++) chk("end_tally", 32'(tally[i]), 32'(exp_cnt[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
